uart_receiver: RTL and testbench

Serial-to-parallel UART receive stage, the downstream counterpart of the UART transmit stage: it consumes the serial line the transmitter drives and delivers bytes to the system. It uses one system clock with an internal 16x oversampling tick. Frame format is 8N1 (1 start, 8 data bits LSB first, 1 stop), with 8E1 optional. Received bytes go out on a parallel bus with a one-cycle strobe; bad frames raise an error strobe.

---
 rtl/uart_receiver.sv | 149 ++++++++++++++
 tb/tb_uart_receiver.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampling UART receive stage for 8N1 frames with byte strobe and error strobe.
// Define UART_RX_PARITY_EN to receive 8E1 frames, where a parity mismatch is reported on RX_ERR.
module uart_receiver #(
    parameter int unsigned BAUD_DIV = 652
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       RX,
    output logic [7:0] RX_DATA,
    output logic       RX_STATUS,
    output logic       RX_ERR
);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

    state_t      state_q, state_d;
    logic        rx_meta_q, rx_s_q;
    logic [15:0] div_q, div_d;
    logic [3:0]  smp_q, smp_d;
    logic [2:0]  bitn_q, bitn_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        status_q, status_d;
    logic        err_q, err_d;
    logic        tick;
    logic        par_ok;
`ifdef UART_RX_PARITY_EN
    logic        par_bad_q, par_bad_d;
`endif

    assign tick      = (div_q == 16'(BAUD_DIV - 1));
    assign RX_DATA   = data_q;
    assign RX_STATUS = status_q;
    assign RX_ERR    = err_q;

    always_comb begin
        state_d  = state_q;
        bitn_d   = bitn_q;
        shift_d  = shift_q;
        data_d   = data_q;
        status_d = 1'b0;
        err_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        par_ok    = !par_bad_q;
`else
        par_ok    = 1'b1;
`endif
        case (state_q)
            IDLE: begin
                if (!rx_s_q) state_d = START;
            end
            START: begin
                // A low that is gone by mid start bit is a glitch, not a frame.
                if (tick && smp_q == 4'd7) begin
                    if (!rx_s_q) begin
                        state_d = DATA;
                        bitn_d  = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (tick && smp_q == 4'd15) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    if (bitn_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bitn_d = bitn_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick && smp_q == 4'd15) begin
                    par_bad_d = ^{shift_q, rx_s_q};
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (tick && smp_q == 4'd15) begin
                    if (rx_s_q && par_ok) begin
                        data_d   = shift_q;
                        status_d = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = rx_s_q ? IDLE : BREAK;
                    end
                end
            end
            BREAK: begin
                // Hold off until the line returns high so a stuck-low line is not re-read as starts.
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_q == IDLE || tick) div_d = 16'd0;
        else                         div_d = div_q + 16'd1;

        if (state_d != state_q) smp_d = 4'd0;
        else if (tick)          smp_d = smp_q + 4'd1;
        else                    smp_d = smp_q;
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= IDLE;
            div_q     <= 16'd0;
            smp_q     <= 4'd0;
            bitn_q    <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            status_q  <= 1'b0;
            err_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            rx_meta_q <= RX;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            div_q     <= div_d;
            smp_q     <= smp_d;
            bitn_q    <= bitn_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            status_q  <= status_d;
            err_q     <= err_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed scenarios plus random frames against a frame-level model.
module tb_uart_receiver;
    localparam int BD  = 4;
    localparam int BIT = 16 * BD;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 2 + 1 + 168 * BD + 1;
`else
    localparam int LAT = 2 + 1 + 152 * BD + 1;
`endif

    logic       sysclk = 1'b0;
    logic       reset;
    logic       RX;
    logic [7:0] RX_DATA;
    logic       RX_STATUS;
    logic       RX_ERR;

    uart_receiver #(.BAUD_DIV(BD)) dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .RX       (RX),
        .RX_DATA  (RX_DATA),
        .RX_STATUS(RX_STATUS),
        .RX_ERR   (RX_ERR)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        logic       err;
        logic [7:0] data;
        int         t;
    } ev_t;

    ev_t        obs_q[$];
    ev_t        exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         both_hi = 0;
    int         fall_cyc = 0;
    logic       par_err_v = 1'b0;
    logic [7:0] exp_data = 8'h00;

    always @(posedge sysclk) cyc <= cyc + 1;

    always @(negedge sysclk) begin
        if (RX_STATUS && RX_ERR) both_hi++;
        if (RX_STATUS) obs_q.push_back('{1'b0, RX_DATA, cyc});
        if (RX_ERR)    obs_q.push_back('{1'b1, 8'h00, cyc});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        RX = v;
        if (n > 0) begin
            repeat (n) @(posedge sysclk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_len);
        fall_cyc = cyc;
        hold(1'b0, BIT);
        for (int i = 0; i < 8; i++) hold(b[i], BIT);
`ifdef UART_RX_PARITY_EN
        hold((^b) ^ par_err_v, BIT);
`endif
        hold(stop_v, stop_len);
    endtask

    // Frame-level model: a frame is good iff its stop bit is high and its parity (if any) matches.
    task automatic expect_frame(input logic [7:0] b, input logic stop_v);
        ev_t e;
        e.t = 0;
        if (stop_v && !par_err_v) begin
            e.err    = 1'b0;
            e.data   = b;
            exp_data = b;
        end else begin
            e.err  = 1'b1;
            e.data = 8'h00;
        end
        exp_q.push_back(e);
    endtask

    task automatic match_events(input string tag);
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk({tag, "_kind"}, obs_q[i].err, exp_q[i].err);
            if (!exp_q[i].err) chk({tag, "_data"}, obs_q[i].data, exp_q[i].data);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] b;
        logic       stop_v;
        int         lat;

        reset = 1'b0;
        RX    = 1'b1;
        repeat (3) @(posedge sysclk);
        #1;
        chk("rst_data", RX_DATA, 8'h00);
        chk("rst_status", RX_STATUS, 1'b0);
        chk("rst_err", RX_ERR, 1'b0);
        reset = 1'b1;
        hold(1'b1, 200);
        match_events("idle");
        chk("idle_data", RX_DATA, 8'h00);

        expect_frame(8'h55, 1'b1);
        send_frame(8'h55, 1'b1, BIT);
        hold(1'b1, 100);
        if (obs_q.size() > 0) begin
            lat = obs_q[0].t - fall_cyc;
            chk("latency_in_window", (lat >= LAT - 1 && lat <= LAT + 1), 1'b1);
        end
        match_events("f55");
        chk("f55_hold", RX_DATA, 8'h55);

        expect_frame(8'hA3, 1'b1);
        send_frame(8'hA3, 1'b1, BIT);
        expect_frame(8'h00, 1'b1);
        send_frame(8'h00, 1'b1, BIT);
        hold(1'b1, 100);
        match_events("b2b");
        chk("b2b_hold", RX_DATA, 8'h00);

        hold(1'b0, 20);
        hold(1'b1, 100);
        match_events("glitch");
        expect_frame(8'h3C, 1'b1);
        send_frame(8'h3C, 1'b1, BIT);
        hold(1'b1, 100);
        match_events("f3c");
        chk("f3c_hold", RX_DATA, 8'h3C);

        expect_frame(8'hFF, 1'b0);
        send_frame(8'hFF, 1'b0, 200);
        hold(1'b1, 200);
        match_events("brk");
        chk("brk_hold", RX_DATA, 8'h3C);
        hold(1'b1, 300);
        match_events("brk_quiet");
        b = 8'($urandom);
        expect_frame(b, 1'b1);
        send_frame(b, 1'b1, BIT);
        hold(1'b1, 100);
        match_events("brk_recover");

        // Abort a frame with reset partway through data bit 4.
        b = 8'hF0;
        hold(1'b0, BIT);
        for (int i = 0; i < 4; i++) hold(b[i], BIT);
        hold(b[4], 20);
        reset = 1'b0;
        hold(b[4], 5);
        exp_data = 8'h00;
        chk("abort_rst_data", RX_DATA, 8'h00);
        RX    = 1'b1;
        reset = 1'b1;
        hold(1'b1, 200);
        match_events("abort");
        chk("abort_data", RX_DATA, 8'h00);
        expect_frame(8'h81, 1'b1);
        send_frame(8'h81, 1'b1, BIT);
        hold(1'b1, 100);
        match_events("f81");
        chk("f81_hold", RX_DATA, 8'h81);

        for (int k = 0; k < 12; k++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                hold(1'b0, $urandom_range(1, 28));
                hold(1'b1, BIT);
            end
            stop_v = ($urandom_range(0, 4) != 0);
`ifdef UART_RX_PARITY_EN
            par_err_v = ($urandom_range(0, 4) == 0);
`endif
            expect_frame(b, stop_v);
            send_frame(b, stop_v, BIT);
            if (!stop_v) hold(1'b1, 20);
            else         hold(1'b1, $urandom_range(0, 40));
        end
        par_err_v = 1'b0;
        hold(1'b1, 100);
        match_events("rand");
        chk("rand_hold", RX_DATA, exp_data);

`ifdef UART_RX_PARITY_EN
        par_err_v = 1'b1;
        expect_frame(8'h07, 1'b1);
        send_frame(8'h07, 1'b1, BIT);
        hold(1'b1, 100);
        match_events("par_bad");
        par_err_v = 1'b0;
        expect_frame(8'h07, 1'b1);
        send_frame(8'h07, 1'b1, BIT);
        hold(1'b1, 100);
        match_events("par_good");
        chk("par_hold", RX_DATA, 8'h07);
`endif

        chk("mutex", both_hi, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
